// File: rtl/md_unit_if.sv
// Request/response bundle between issue logic and the multi-cycle multiply/divide unit.
`default_nettype none

interface md_unit_if #(
   parameter int XLEN = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [1:0]          in_op;
   logic [XLEN-1:0]     in_a;
   logic [XLEN-1:0]     in_b;
   logic                flush;
   logic                out_valid;
   logic                out_ready;
   logic [2*XLEN-1:0]   out_r;

   modport master (
      output in_valid, in_op, in_a, in_b, flush, out_ready,
      input  in_ready, out_valid, out_r
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, flush, out_ready,
      output in_ready, out_valid, out_r
   );
endinterface

`default_nettype wire

// File: rtl/md_unit.sv
// Multi-cycle integer multiply/divide: shift-add multiply, restoring divide, one op in flight.
// Results use ALU packing: {hi, lo} product or {rem, quot}.
`default_nettype none

module md_unit #(
   parameter int XLEN           = 32,
   parameter int MUL_RADIX_BITS = 1
) (
   input  logic     clk,
   input  logic     rst,
   md_unit_if.slave bus
);
   localparam int R  = MUL_RADIX_BITS;
   localparam int CW = $clog2(XLEN);
   localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / R - 1);
   localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              state, state_nx;
   logic                is_div;
   logic                neg_lo;
   logic                neg_hi;
   logic [XLEN-1:0]     b_mag;
   logic [2*XLEN-1:0]   acc;
   logic [CW-1:0]       cnt;
   logic [2*XLEN-1:0]   res;

   logic                accept;
   logic                a_neg, b_neg;
   logic [XLEN-1:0]     a_mag_in, b_mag_in;
   logic                div_zero, div_ovf;
   logic                last;
   logic [XLEN+R-1:0]   mul_add, mul_sum;
   logic [2*XLEN-1:0]   mul_nx, div_nx;
   logic [XLEN+1:0]     div_diff;
   logic [XLEN-1:0]     quot, rem;
   logic [2*XLEN-1:0]   fixed;

   assign accept   = bus.in_valid && (state == S_IDLE) && !bus.flush;
   assign a_neg    = !bus.in_op[0] && bus.in_a[XLEN-1];
   assign b_neg    = !bus.in_op[0] && bus.in_b[XLEN-1];
   assign a_mag_in = a_neg ? -bus.in_a : bus.in_a;
   assign b_mag_in = b_neg ? -bus.in_b : bus.in_b;
   assign div_zero = bus.in_op[1] && (bus.in_b == '0);
   assign div_ovf  = (bus.in_op == 2'd2) && (bus.in_a == {1'b1, {(XLEN-1){1'b0}}})
                     && (bus.in_b == '1);
   assign last     = (cnt == (is_div ? DIV_LAST : MUL_LAST));

   // Multiply step: add multiplicand times the low R multiplier bits, then shift right by R.
   always_comb begin
      mul_add = '0;
      for (int j = 0; j < R; j++) begin
         if (acc[j]) begin
            mul_add = mul_add + ({{R{1'b0}}, b_mag} << j);
         end
      end
      mul_sum = {{R{1'b0}}, acc[2*XLEN-1:XLEN]} + mul_add;
      mul_nx  = {mul_sum, acc[XLEN-1:R]};
   end

   // Restoring divide step: acc = {partial remainder, dividend bits shifting into quotient}.
   always_comb begin
      div_diff = {1'b0, acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {2'b00, b_mag};
      if (div_diff[XLEN+1]) begin
         div_nx = {acc[2*XLEN-2:0], 1'b0};
      end else begin
         div_nx = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end
   end

   always_comb begin
      quot  = neg_lo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      rem   = neg_hi ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      fixed = is_div ? {rem, quot} : (neg_lo ? -acc : acc);
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (accept) state_nx = (div_zero || div_ovf) ? S_DONE : S_CALC;
         S_CALC: if (last) state_nx = S_FIX;
         S_FIX:  state_nx = S_DONE;
         S_DONE: if (bus.out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (bus.flush) begin
         state_nx = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         is_div <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         b_mag  <= '0;
         acc    <= '0;
         cnt    <= '0;
         res    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  is_div <= bus.in_op[1];
                  neg_lo <= a_neg ^ b_neg;
                  neg_hi <= a_neg;
                  b_mag  <= b_mag_in;
                  acc    <= {{XLEN{1'b0}}, a_mag_in};
                  cnt    <= '0;
                  if (div_zero) begin
                     res <= {bus.in_a, {XLEN{1'b1}}};
                  end else if (div_ovf) begin
                     res <= {{XLEN{1'b0}}, bus.in_a};
                  end
               end
            end
            S_CALC: begin
               acc <= is_div ? div_nx : mul_nx;
               cnt <= cnt + 1'b1;
            end
            S_FIX: begin
               res <= fixed;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == S_IDLE);
   assign bus.out_valid = (state == S_DONE);
   assign bus.out_r     = res;
endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// Directed and randomised checks of md_unit: results, latency, back-pressure, flush and reset.
`default_nettype none

module tb_md_unit;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   md_unit_if #(.XLEN(XLEN)) bus ();

   md_unit #(.XLEN(XLEN), .MUL_RADIX_BITS(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      int     ia, ib, q, r;
      longint sa, sb;
      logic [63:0] ua, ub;
      ia = a;
      ib = b;
      case (op)
         2'd0: begin
            sa = ia;
            sb = ib;
            return sa * sb;
         end
         2'd1: begin
            ua = {32'h0, a};
            ub = {32'h0, b};
            return ua * ub;
         end
         2'd2: begin
            if (b == 32'h0) return {a, 32'hFFFFFFFF};
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, a};
            q = ia / ib;
            r = ia % ib;
            return {r, q};
         end
         default: begin
            if (b == 32'h0) return {a, 32'hFFFFFFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         default: return $urandom;
      endcase
   endfunction

   // Presents one request and returns #1 after the accepting edge; operands are then scrambled.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_a     = a;
      bus.in_b     = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_op    = 2'($urandom);
      bus.in_a     = $urandom;
      bus.in_b     = $urandom;
   endtask

   task automatic wait_result(output logic [63:0] r, output int lat);
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!bus.out_valid) check("timeout", 64'(bus.out_valid), 64'd1);
      r = bus.out_r;
   endtask

   task automatic handshake();
      check("done_in_ready", 64'(bus.in_ready), 64'd0);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("hs_out_valid", 64'(bus.out_valid), 64'd0);
      check("hs_in_ready", 64'(bus.in_ready), 64'd1);
   endtask

   task automatic run_dir(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat_exp);
      logic [63:0] r;
      int          lat;
      issue(op, a, b);
      wait_result(r, lat);
      check(tag, r, exp);
      check({tag, "_lat"}, 64'(lat), 64'(lat_exp));
      handshake();
   endtask

   initial begin
      logic [63:0] r, exp;
      logic [1:0]  op;
      logic [31:0] a, b;
      int          lat;

      bus.in_valid  = 1'b0;
      bus.in_op     = 2'd0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_r", bus.out_r, 64'h0);
      @(negedge clk);
      rst = 1'b0;

      // MUL -3*7 with 10 cycles of back-pressure in DONE
      issue(2'd0, 32'hFFFFFFFD, 32'd7);
      wait_result(r, lat);
      check("mul_neg", r, 64'hFFFFFFFF_FFFFFFEB);
      check("mul_neg_lat", 64'(lat), 64'd34);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_valid", 64'(bus.out_valid), 64'd1);
         check("bp_out_r", bus.out_r, 64'hFFFFFFFF_FFFFFFEB);
         check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      end
      handshake();

      run_dir("mulu_max",  2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 34);
      run_dir("mul_min",   2'd0, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 34);
      run_dir("div_neg",   2'd2, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 34);
      run_dir("div_neg2",  2'd2, 32'hFFFFFF9C, 32'd7,        64'hFFFFFFFE_FFFFFFF2, 34);
      run_dir("divu",      2'd3, 32'd100,      32'd7,        64'h00000002_0000000E, 34);
      run_dir("divu_min",  2'd3, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 34);
      run_dir("div_zero",  2'd2, 32'd5,        32'd0,        64'h00000005_FFFFFFFF, 1);
      run_dir("divu_zero", 2'd3, 32'hFFFFFFF0, 32'd0,        64'hFFFFFFF0_FFFFFFFF, 1);
      run_dir("div_ovf",   2'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1);

      // flush at CALC cycle 10, with a competing request that must be ignored
      issue(2'd0, 32'd123, 32'd456);
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_op    = 2'd1;
      bus.in_a     = 32'd2;
      bus.in_b     = 32'd3;
      @(posedge clk);
      #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_out_valid", 64'(bus.out_valid), 64'd0);
      check("flush_in_ready", 64'(bus.in_ready), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      check("flush_idle", 64'(bus.in_ready), 64'd1);

      // reset at CALC cycle 5
      issue(2'd2, 32'd1000, 32'd7);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst2_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst2_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst2_out_r", bus.out_r, 64'h0);
      repeat (40) @(posedge clk);
      #1;
      check("rst2_no_result", 64'(bus.out_valid), 64'd0);
      run_dir("after_rst", 2'd3, 32'd1000, 32'd7, 64'h00000006_0000008E, 34);

      // randomised ops with random back-pressure
      for (int n = 0; n < 600; n++) begin
         op  = 2'($urandom_range(0, 3));
         a   = pick();
         b   = pick();
         exp = model(op, a, b);
         issue(op, a, b);
         wait_result(r, lat);
         check("rand", r, exp);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
         end
         check("rand_hold", bus.out_r, exp);
         handshake();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule

`default_nettype wire
